// File: rtl/sad_accumulator_pkg.sv
// Shared width rules for the SAD accumulator pipeline.
// Every width is derived from the pixel width, lane count and block length.
package sad_accumulator_pkg;

  // Result width: worst case LANES*BEATS*(2^PIX_W-1) fits exactly.
  function automatic int unsigned sad_acc_w(input int unsigned pix_w, input int unsigned lanes,
                                            input int unsigned beats);
    return pix_w + $clog2(lanes * beats);
  endfunction

  // Width of one reduced beat (sum of all lane differences).
  function automatic int unsigned sad_s2_w(input int unsigned pix_w, input int unsigned lanes);
    return pix_w + $clog2(lanes);
  endfunction

  function automatic int unsigned sad_cnt_w(input int unsigned beats);
    return $clog2(beats) + 1;
  endfunction

endpackage

// File: rtl/sad_accumulator_if.sv
// Beat input, flush and result handshake bundle for sad_accumulator.
// The master side is the pixel fetch / result consumer; the slave side is the engine.
interface sad_accumulator_if #(
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned LANES       = 4,
  parameter int unsigned BLOCK_BEATS = 16
);
  import sad_accumulator_pkg::*;

  localparam int unsigned AccW = sad_acc_w(PIX_W, LANES, BLOCK_BEATS);
  localparam int unsigned CntW = sad_cnt_w(BLOCK_BEATS);

  logic                   i_valid;
  logic                   o_ready;
  logic [LANES*PIX_W-1:0] i_pix_a;
  logic [LANES*PIX_W-1:0] i_pix_b;
  logic                   i_flush;
  logic [AccW-1:0]        o_sad;
  logic                   o_sad_valid;
  logic                   i_sad_ready;
  logic [CntW-1:0]        o_beat_cnt;

  modport master (
    output i_valid, i_pix_a, i_pix_b, i_flush, i_sad_ready,
    input  o_ready, o_sad, o_sad_valid, o_beat_cnt
  );

  modport slave (
    input  i_valid, i_pix_a, i_pix_b, i_flush, i_sad_ready,
    output o_ready, o_sad, o_sad_valid, o_beat_cnt
  );

endinterface

// File: rtl/sad_csa_tree.sv
// Combinational carry-save reduction of LANES unsigned lane values into a sum/carry pair.
// Each step is a row of full-adder cells; sum_o + carry_o equals the exact lane total.
module sad_csa_tree
  import sad_accumulator_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned PIX_W = 8
) (
  input  logic [LANES*PIX_W-1:0]                 lanes_i,
  output logic [sad_s2_w(PIX_W, LANES)-1:0]      sum_o,
  output logic [sad_s2_w(PIX_W, LANES)-1:0]      carry_o
);

  localparam int unsigned S2W = sad_s2_w(PIX_W, LANES);

  logic [S2W-1:0] s;
  logic [S2W-1:0] c;
  logic [S2W-1:0] row;
  logic [S2W-1:0] s_nxt;
  logic [S2W-1:0] c_nxt;

  // Carries shifted out of the top bit are dropped: the true total fits S2W.
  always_comb begin
    s     = '0;
    c     = '0;
    row   = '0;
    s_nxt = '0;
    c_nxt = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      row   = S2W'(lanes_i[k*PIX_W +: PIX_W]);
      s_nxt = s ^ c ^ row;
      c_nxt = ((s & c) | (s & row) | (c & row)) << 1;
      s     = s_nxt;
      c     = c_nxt;
    end
  end

  assign sum_o   = s;
  assign carry_o = c;

endmodule

// File: rtl/sad_accumulator.sv
// Three-stage SAD engine: per-lane |a-b|, carry-save lane reduction, block accumulation.
// A pending, untaken result stalls every stage; flush drops partial work but never the result.
module sad_accumulator
  import sad_accumulator_pkg::*;
#(
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned LANES       = 4,
  parameter int unsigned BLOCK_BEATS = 16
) (
  input logic               i_clk,
  input logic               i_rst_n,
  sad_accumulator_if.slave  bus
);

  localparam int unsigned S2W  = sad_s2_w(PIX_W, LANES);
  localparam int unsigned AccW = sad_acc_w(PIX_W, LANES, BLOCK_BEATS);
  localparam int unsigned CntW = sad_cnt_w(BLOCK_BEATS);
  localparam logic [CntW-1:0] LastCnt = CntW'(BLOCK_BEATS - 1);

  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   v1_q, v1_d;
  logic                   last1_q, last1_d;
  logic [LANES*PIX_W-1:0] d1_q, d1_d;
  logic                   v2_q, v2_d;
  logic                   last2_q, last2_d;
  logic [S2W-1:0]         s2_q, s2_d;
  logic [AccW-1:0]        acc_q, acc_d;
  logic [AccW-1:0]        sad_q, sad_d;
  logic                   sad_valid_q, sad_valid_d;

  logic                   stall;
  logic                   ready;
  logic                   accept;
  logic                   last_beat;
  logic [LANES*PIX_W-1:0] abs_diff;
  logic [PIX_W-1:0]       pa;
  logic [PIX_W-1:0]       pb;
  logic [S2W-1:0]         csa_sum;
  logic [S2W-1:0]         csa_carry;
  logic [AccW-1:0]        acc_sum;

  assign stall     = sad_valid_q & ~bus.i_sad_ready;
  assign ready     = i_rst_n & ~stall;
  assign accept    = bus.i_valid & ready & ~bus.i_flush;
  assign last_beat = (cnt_q == LastCnt);
  assign acc_sum   = acc_q + AccW'(s2_q);

  always_comb begin
    abs_diff = '0;
    pa       = '0;
    pb       = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      pa = bus.i_pix_a[k*PIX_W +: PIX_W];
      pb = bus.i_pix_b[k*PIX_W +: PIX_W];
      abs_diff[k*PIX_W +: PIX_W] = (pa >= pb) ? (pa - pb) : (pb - pa);
    end
  end

  sad_csa_tree #(
    .LANES (LANES),
    .PIX_W (PIX_W)
  ) u_csa_tree (
    .lanes_i (d1_q),
    .sum_o   (csa_sum),
    .carry_o (csa_carry)
  );

  always_comb begin
    cnt_d       = cnt_q;
    v1_d        = v1_q;
    last1_d     = last1_q;
    d1_d        = d1_q;
    v2_d        = v2_q;
    last2_d     = last2_q;
    s2_d        = s2_q;
    acc_d       = acc_q;
    sad_d       = sad_q;
    sad_valid_d = sad_valid_q;

    if (bus.i_flush) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = last_beat ? '0 : cnt_q + CntW'(1);
    end

    if (sad_valid_q && bus.i_sad_ready) begin
      sad_valid_d = 1'b0;
    end

    if (!stall) begin
      v1_d    = accept;
      last1_d = last_beat;
      d1_d    = abs_diff;
      v2_d    = v1_q;
      last2_d = last1_q;
      s2_d    = csa_sum + csa_carry;
      if (v2_q) begin
        if (last2_q) begin
          // A result taken this cycle is replaced in place; valid stays high.
          sad_d       = acc_sum;
          sad_valid_d = 1'b1;
          acc_d       = '0;
        end else begin
          acc_d = acc_sum;
        end
      end
    end

    if (bus.i_flush) begin
      v1_d  = 1'b0;
      v2_d  = 1'b0;
      acc_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q       <= '0;
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      d1_q        <= '0;
      v2_q        <= 1'b0;
      last2_q     <= 1'b0;
      s2_q        <= '0;
      acc_q       <= '0;
      sad_q       <= '0;
      sad_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      v1_q        <= v1_d;
      last1_q     <= last1_d;
      d1_q        <= d1_d;
      v2_q        <= v2_d;
      last2_q     <= last2_d;
      s2_q        <= s2_d;
      acc_q       <= acc_d;
      sad_q       <= sad_d;
      sad_valid_q <= sad_valid_d;
    end
  end

  assign bus.o_ready     = ready;
  assign bus.o_sad       = sad_q;
  assign bus.o_sad_valid = sad_valid_q;
  assign bus.o_beat_cnt  = cnt_q;

endmodule

// File: tb/tb_sad_accumulator.sv
// Directed bench for sad_accumulator: a block-level SAD model predicts every result and the
// beat count each cycle, with literal expectations on the headline cases.
module tb_sad_accumulator;

  localparam int unsigned PIX_W       = 8;
  localparam int unsigned LANES       = 4;
  localparam int unsigned BLOCK_BEATS = 16;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sad_accumulator_if #(
    .PIX_W       (PIX_W),
    .LANES       (LANES),
    .BLOCK_BEATS (BLOCK_BEATS)
  ) bus ();

  sad_accumulator #(
    .PIX_W       (PIX_W),
    .LANES       (LANES),
    .BLOCK_BEATS (BLOCK_BEATS)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int unsigned cyc = 0;
  int unsigned exp_q[$];
  int unsigned pop_cyc[$];
  int unsigned m_cnt  = 0;
  int unsigned m_part = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int unsigned beat_sad(input logic [31:0] a, input logic [31:0] b);
    int unsigned s;
    int x;
    int y;
    s = 0;
    for (int k = 0; k < int'(LANES); k++) begin
      x = int'(a[k*8 +: 8]);
      y = int'(b[k*8 +: 8]);
      s += (x > y) ? int'(x - y) : int'(y - x);
    end
    return s;
  endfunction

  // Block-level model and per-cycle compare, evaluated mid-cycle before the next edge.
  always @(negedge clk) begin
    logic exp_ready;
    cyc++;
    exp_ready = rst_n && !(bus.o_sad_valid && !bus.i_sad_ready);
    check("beat_cnt", 64'(bus.o_beat_cnt), 64'(m_cnt));
    check("ready_rule", 64'(bus.o_ready), 64'(exp_ready));
    if (bus.o_sad_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sad_unexpected", 64'(bus.o_sad_valid), 64'd0);
      end else begin
        check("sad_value", 64'(bus.o_sad), 64'(exp_q[0]));
        if (bus.i_sad_ready) begin
          void'(exp_q.pop_front());
          pop_cyc.push_back(cyc);
        end
      end
    end
    if (!rst_n) begin
      m_cnt  = 0;
      m_part = 0;
      exp_q.delete();
    end else if (bus.i_flush) begin
      m_cnt  = 0;
      m_part = 0;
    end else if (bus.i_valid && exp_ready) begin
      m_part += beat_sad(bus.i_pix_a, bus.i_pix_b);
      m_cnt++;
      if (m_cnt == BLOCK_BEATS) begin
        exp_q.push_back(m_part);
        m_cnt  = 0;
        m_part = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves i_valid high so consecutive calls form a gap-free beat stream.
  task automatic send_beats(input logic [31:0] a, input logic [31:0] b, input int n);
    int  guard;
    logic took;
    for (int i = 0; i < n; i++) begin
      bus.i_valid = 1'b1;
      bus.i_pix_a = a;
      bus.i_pix_b = b;
      guard = 0;
      took  = 1'b0;
      do begin
        @(negedge clk);
        took = bus.o_ready;
        @(posedge clk);
        #1;
        guard++;
      end while (!took && guard < 200);
      if (!took) check("send_timeout", 64'd0, 64'd1);
    end
  endtask

  task automatic wait_sad(output logic found);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus.o_sad_valid === 1'b1) found = 1'b1;
    end
    if (!found) check("sad_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    logic found_bp;
    int   base;

    rst_n           = 1'b0;
    bus.i_valid     = 1'b1;
    bus.i_pix_a     = '1;
    bus.i_pix_b     = '0;
    bus.i_flush     = 1'b0;
    bus.i_sad_ready = 1'b1;

    // Reset held with a valid beat presented.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sad_valid", 64'(bus.o_sad_valid), 64'd0);
    check("rst_beat_cnt", 64'(bus.o_beat_cnt), 64'd0);
    check("rst_ready", 64'(bus.o_ready), 64'd0);
    check("rst_sad", 64'(bus.o_sad), 64'd0);
    step();
    rst_n       = 1'b1;
    bus.i_valid = 1'b0;
    @(negedge clk);
    check("post_rst_cnt", 64'(bus.o_beat_cnt), 64'd0);
    step();

    // Full-scale block and result latency.
    send_beats(32'hFFFF_FFFF, 32'h0000_0000, 16);
    bus.i_valid = 1'b0;
    @(negedge clk);
    check("lat_c1_valid", 64'(bus.o_sad_valid), 64'd0);
    @(negedge clk);
    check("lat_c2_valid", 64'(bus.o_sad_valid), 64'd0);
    @(negedge clk);
    check("lat_c3_valid", 64'(bus.o_sad_valid), 64'd1);
    check("max_sad", 64'(bus.o_sad), 64'd16320);
    step();

    // Mixed-sign lanes: lane0 a=10 b=3, lane1 0/9, lane2 200/100, lane3 5/5.
    send_beats(32'h05C8_000A, 32'h0564_0903, 16);
    bus.i_valid = 1'b0;
    wait_sad(found);
    if (found) check("mixed_sad", 64'(bus.o_sad), 64'd1856);
    step();

    // Backpressure: the next block starts while the result is pending.
    bus.i_sad_ready = 1'b0;
    send_beats(32'h0202_0202, 32'h0000_0000, 16);
    fork
      send_beats(32'h0303_0303, 32'h0000_0000, 16);
      begin
        wait_sad(found_bp);
        repeat (6) begin
          @(negedge clk);
          check("bp_ready", 64'(bus.o_ready), 64'd0);
          check("bp_sad_hold", 64'(bus.o_sad), 64'd128);
          check("bp_cnt_hold", 64'(bus.o_beat_cnt), 64'd2);
        end
        step();
        bus.i_sad_ready = 1'b1;
      end
    join
    bus.i_valid = 1'b0;
    wait_sad(found);
    if (found) check("bp_next_sad", 64'(bus.o_sad), 64'd192);
    step();

    // Flush a 7-beat partial block; the flush-cycle beat must not count.
    send_beats(32'h3232_3232, 32'h0000_0000, 7);
    bus.i_valid = 1'b0;
    step();
    step();
    bus.i_flush = 1'b1;
    bus.i_valid = 1'b1;
    step();
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    @(negedge clk);
    check("flush_cnt", 64'(bus.o_beat_cnt), 64'd0);
    step();
    send_beats(32'h1020_3040, 32'h1121_3141, 16);
    bus.i_valid = 1'b0;
    wait_sad(found);
    if (found) check("flush_then_sad", 64'(bus.o_sad), 64'd64);
    step();

    // Flush while a result is pending: the result survives, in-flight beats vanish.
    bus.i_sad_ready = 1'b0;
    send_beats(32'h0404_0404, 32'h0000_0000, 16);
    send_beats(32'h0505_0505, 32'h0000_0000, 2);
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b1;
    step();
    bus.i_flush = 1'b0;
    @(negedge clk);
    check("flush_keep_valid", 64'(bus.o_sad_valid), 64'd1);
    check("flush_keep_sad", 64'(bus.o_sad), 64'd256);
    check("flush_pend_cnt", 64'(bus.o_beat_cnt), 64'd0);
    step();
    bus.i_sad_ready = 1'b1;
    step();

    // Three random blocks back to back.
    base = pop_cyc.size();
    for (int i = 0; i < 48; i++) begin
      send_beats($urandom, $urandom, 1);
    end
    bus.i_valid = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("b2b_count", 64'(pop_cyc.size() - base), 64'd3);
    if (pop_cyc.size() >= base + 3) begin
      check("b2b_gap1", 64'(pop_cyc[base+1] - pop_cyc[base]), 64'd16);
      check("b2b_gap2", 64'(pop_cyc[base+2] - pop_cyc[base+1]), 64'd16);
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
